// File: rtl/branch_ctrl_if.sv
// rtl/branch_ctrl_if.sv - ID-stage branch controller signal bundle
interface branch_ctrl_if #(
    parameter int CNT_WIDTH  = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  id_valid;
    logic                  id_branch;
    logic                  id_bne;
    logic [ADDR_WIDTH-1:0] id_rs_addr;
    logic [ADDR_WIDTH-1:0] id_rt_addr;
    logic [31:0]           id_branch_target;
    logic                  ex_wreg;
    logic [ADDR_WIDTH-1:0] ex_waddr;
    logic                  ex_is_load;
    logic                  mem_wreg;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic                  mem_is_load;
    logic                  is_rs_rt_eq;
    logic                  ext_stall;
    logic                  flush_in;
    logic                  stall_req;
    logic                  flush_if;
    logic                  pc_src_branch;
    logic [31:0]           branch_pc;
    logic                  busy;
    logic [CNT_WIDTH-1:0]  branch_cnt;
    logic [CNT_WIDTH-1:0]  taken_cnt;

    // Pipeline side: drives ID/EX/MEM status, consumes redirect controls
    modport master (
        output id_valid, id_branch, id_bne, id_rs_addr, id_rt_addr, id_branch_target,
        output ex_wreg, ex_waddr, ex_is_load, mem_wreg, mem_waddr, mem_is_load,
        output is_rs_rt_eq, ext_stall, flush_in,
        input  stall_req, flush_if, pc_src_branch, branch_pc, busy, branch_cnt, taken_cnt
    );

    // Controller side
    modport slave (
        input  id_valid, id_branch, id_bne, id_rs_addr, id_rt_addr, id_branch_target,
        input  ex_wreg, ex_waddr, ex_is_load, mem_wreg, mem_waddr, mem_is_load,
        input  is_rs_rt_eq, ext_stall, flush_in,
        output stall_req, flush_if, pc_src_branch, branch_pc, busy, branch_cnt, taken_cnt
    );
endinterface

// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - ID-stage beq/bne hazard stall, resolve and statistics
module branch_ctrl #(
    parameter int CNT_WIDTH  = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic         clk,
    input  logic         rst,
    branch_ctrl_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [1:0]     cnt;
    logic [1:0]     cnt_nxt;
    logic           ex_match;
    logic           mem_match;
    logic           dep_ex;
    logic           dep_mem;
    logic [1:0]     need;
    logic           stall;
    logic           resolve;
    logic           taken;
    logic [CNT_WIDTH-1:0] branch_cnt_q;
    logic [CNT_WIDTH-1:0] taken_cnt_q;

    // Operand hazard detection; r0 is hardwired and never creates a dependency
    always_comb begin
        ex_match  = (bus.ex_waddr != '0) &&
                    (bus.ex_waddr == bus.id_rs_addr || bus.ex_waddr == bus.id_rt_addr);
        mem_match = (bus.mem_waddr != '0) &&
                    (bus.mem_waddr == bus.id_rs_addr || bus.mem_waddr == bus.id_rt_addr);
        dep_ex    = bus.ex_wreg && ex_match;
        dep_mem   = bus.mem_wreg && bus.mem_is_load && mem_match;
        need      = 2'd0;
        if (dep_ex) begin
            need = bus.ex_is_load ? 2'd2 : 2'd1;
        end else if (dep_mem) begin
            need = 2'd1;
        end
    end

    // State and remaining-stall counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state, stall and resolve decisions; ext_stall freezes, flush_in aborts
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        resolve   = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (!bus.ext_stall && !bus.flush_in && bus.id_valid && bus.id_branch) begin
                        if (need != 2'd0) begin
                            stall     = 1'b1;
                            state_nxt = WAIT;
                            cnt_nxt   = need - 2'd1;
                        end else begin
                            resolve = 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (bus.flush_in) begin
                        state_nxt = IDLE;
                        cnt_nxt   = 2'd0;
                    end else if (bus.ext_stall) begin
                        state_nxt = WAIT;
                    end else if (cnt != 2'd0) begin
                        stall   = 1'b1;
                        cnt_nxt = cnt - 2'd1;
                    end else begin
                        resolve   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = 2'd0;
                end
            endcase
        end
        taken = resolve && (bus.id_bne ? !bus.is_rs_rt_eq : bus.is_rs_rt_eq);
    end

    // Branch statistics, wrapping naturally at the counter width
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else if (resolve) begin
            branch_cnt_q <= branch_cnt_q + CNT_WIDTH'(1);
            if (taken) begin
                taken_cnt_q <= taken_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.stall_req     = stall;
    assign bus.pc_src_branch = taken;
    assign bus.flush_if      = taken;
    assign bus.branch_pc     = resolve ? bus.id_branch_target : 32'd0;
    assign bus.busy          = (state == WAIT) && !rst;
    assign bus.branch_cnt    = branch_cnt_q;
    assign bus.taken_cnt     = taken_cnt_q;
endmodule
